// File: rtl/edge_pkg.sv
// Shared types and defaults for the edge scan controller and its window.
package edge_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    SCAN      = 2'd2,
    CLOSE     = 2'd3
  } state_t;

  // Marker for "no edge in this row"
  localparam logic [7:0] NO_EDGE = 8'hFF;

  // Default geometry and detection settings
  localparam int unsigned DEF_WIDTH      = 176;
  localparam int unsigned DEF_HEIGHT     = 144;
  localparam int unsigned DEF_TAPS       = 11;
  localparam int unsigned DEF_CENTER     = 5;
  localparam int unsigned DEF_SUM_THRESH = 3;
  localparam int unsigned DEF_PIX_W      = 3;

  // Window sum width; holds 11 taps of 3-bit pixels without overflow
  localparam int unsigned SUM_W = 7;

  // Row summary payload held in the output register
  typedef struct packed {
    logic [7:0] idx;
    logic [7:0] first;
    logic [7:0] last;
    logic [7:0] cnt;
  } row_sum_t;

  // Saturating 8-bit increment
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/edge_window.sv
// TAPS-deep pixel shift register producing the window sum and raw edge flag.
// Tap 0 is the oldest pixel; new pixels enter at tap TAPS-1.
module edge_window
  import edge_pkg::*;
#(
  parameter int unsigned TAPS       = DEF_TAPS,
  parameter int unsigned CENTER     = DEF_CENTER,
  parameter int unsigned SUM_THRESH = DEF_SUM_THRESH,
  parameter int unsigned PIX_W      = DEF_PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift,
  input  logic [PIX_W-1:0] pix,
  output logic [SUM_W-1:0] sum_c,
  output logic             edge_c
);

  localparam int unsigned WIN_W = TAPS * PIX_W;

  logic [WIN_W-1:0] win;

  // Window storage: clear wins over shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win <= '0;
    end else if (clear) begin
      win <= '0;
    end else if (shift) begin
      win <= {pix, win[WIN_W-1:PIX_W]};
    end
  end

  // Sum of all taps
  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < TAPS; i++) begin
      sum_c = sum_c + SUM_W'(win[i*PIX_W +: PIX_W]);
    end
  end

  // Raw edge: busy neighbourhood around a dark centre pixel
  assign edge_c = (sum_c > SUM_W'(SUM_THRESH)) &&
                  (win[CENTER*PIX_W +: PIX_W] == '0);

endmodule

// File: rtl/edge_scan_controller.sv
// Line-by-line edge scanner: frames the pixel stream with VSYNC/HREF, runs
// each line through an edge window and publishes a per-row summary
// (first/last edge column, edge count) over a valid/ready handshake.
// Build option EDGE_DEBOUNCE_EN: a run of adjacent edge columns counts once
// and LAST_COL records the start of the last run.
module edge_scan_controller
  import edge_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned HEIGHT     = DEF_HEIGHT,
  parameter int unsigned TAPS       = DEF_TAPS,
  parameter int unsigned CENTER     = DEF_CENTER,
  parameter int unsigned SUM_THRESH = DEF_SUM_THRESH,
  parameter int unsigned PIX_W      = DEF_PIX_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             VSYNC,
  input  logic             HREF,
  input  logic             PIX_VALID,
  input  logic [PIX_W-1:0] PIX,
  output logic             ROW_VALID,
  input  logic             ROW_READY,
  output logic [7:0]       ROW_IDX,
  output logic [7:0]       FIRST_COL,
  output logic [7:0]       LAST_COL,
  output logic [7:0]       EDGE_CNT,
  output logic             FRAME_DONE,
  output logic             OVERRUN
);

  localparam int unsigned COL_W  = 9;
  localparam int unsigned FILL_W = $clog2(TAPS + 1);
  localparam int unsigned LAG    = TAPS - 1 - CENTER;

  state_t state;
  state_t state_nx;

  logic              frame_start_c;
  logic              line_start_c;
  logic              line_close_c;
  logic              shift_c;

  logic [COL_W-1:0]  col;
  logic [FILL_W-1:0] fill;
  logic              eval_q;
  logic [7:0]        newest_q;
  logic [7:0]        row;

  logic [SUM_W-1:0]  win_sum;
  logic              win_edge;
  logic              hit_c;
  logic              count_c;
  logic [7:0]        edge_col_c;

  logic [7:0]        first_t;
  logic [7:0]        last_t;
  logic [7:0]        cnt_t;

  logic              out_valid;
  row_sum_t          out_sum;
  logic              overrun_q;
  logic              frame_done_q;

  // Window sum is observation-only at this level
  logic              unused_sum;
  assign unused_sum = ^win_sum;

  // FSM state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and per-cycle line controls; VSYNC restarts the frame from any state
  always_comb begin
    state_nx      = state;
    frame_start_c = VSYNC;
    line_start_c  = 1'b0;
    line_close_c  = 1'b0;
    shift_c       = 1'b0;
    if (VSYNC) begin
      state_nx = WAIT_LINE;
    end else begin
      case (state)
        IDLE: begin
          state_nx = IDLE;
        end
        WAIT_LINE: begin
          if (HREF) begin
            state_nx     = SCAN;
            line_start_c = 1'b1;
          end
        end
        SCAN: begin
          if (!HREF) begin
            state_nx = CLOSE;
          end else begin
            shift_c = PIX_VALID && (col < COL_W'(WIDTH));
          end
        end
        CLOSE: begin
          line_close_c = 1'b1;
          state_nx     = (row == 8'(HEIGHT - 1)) ? IDLE : WAIT_LINE;
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  edge_window #(
    .TAPS       (TAPS),
    .CENTER     (CENTER),
    .SUM_THRESH (SUM_THRESH),
    .PIX_W      (PIX_W)
  ) u_window (
    .clk    (CLK),
    .rst    (RESET),
    .clear  (line_start_c),
    .shift  (shift_c),
    .pix    (PIX),
    .sum_c  (win_sum),
    .edge_c (win_edge)
  );

  // Column/fill counters and the one-cycle evaluation pipeline behind each shift
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      col      <= '0;
      fill     <= '0;
      eval_q   <= 1'b0;
      newest_q <= '0;
    end else if (frame_start_c || line_start_c) begin
      col    <= '0;
      fill   <= '0;
      eval_q <= 1'b0;
    end else begin
      eval_q <= shift_c;
      if (shift_c) begin
        newest_q <= 8'(col);
        col      <= col + COL_W'(1);
        if (fill < FILL_W'(TAPS)) begin
          fill <= fill + FILL_W'(1);
        end
      end
    end
  end

  // Edge qualified only once the window holds a full set of real pixels
  assign hit_c      = eval_q && (fill >= FILL_W'(TAPS)) && win_edge;
  assign edge_col_c = newest_q - 8'(LAG);

`ifdef EDGE_DEBOUNCE_EN
  logic prev_hit;

  // Previous evaluated flag, for run-start detection within a line
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prev_hit <= 1'b0;
    end else if (line_start_c) begin
      prev_hit <= 1'b0;
    end else if (eval_q) begin
      prev_hit <= hit_c;
    end
  end

  assign count_c = hit_c && !prev_hit;
`else
  assign count_c = hit_c;
`endif

  // Per-line edge trackers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      first_t <= NO_EDGE;
      last_t  <= NO_EDGE;
      cnt_t   <= '0;
    end else if (line_start_c) begin
      first_t <= NO_EDGE;
      last_t  <= NO_EDGE;
      cnt_t   <= '0;
    end else begin
      if (hit_c && (first_t == NO_EDGE)) begin
        first_t <= edge_col_c;
      end
      if (count_c) begin
        last_t <= edge_col_c;
        cnt_t  <= sat_inc8(cnt_t);
      end
    end
  end

  // Row counter within the frame
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      row <= '0;
    end else if (frame_start_c) begin
      row <= '0;
    end else if (line_close_c) begin
      row <= row + 8'd1;
    end
  end

  // Output register, overrun flag and frame-done pulse
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_valid    <= 1'b0;
      out_sum      <= '{idx: 8'd0, first: NO_EDGE, last: NO_EDGE, cnt: 8'd0};
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= out_valid && ROW_READY && (out_sum.idx == 8'(HEIGHT - 1));
      if (line_close_c) begin
        // A summary leaving this cycle frees the slot for the new one
        if (!out_valid || ROW_READY) begin
          out_valid <= 1'b1;
          out_sum   <= '{idx: row, first: first_t, last: last_t, cnt: cnt_t};
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (out_valid && ROW_READY) begin
        out_valid <= 1'b0;
      end
      if (frame_start_c) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign ROW_VALID  = out_valid;
  assign ROW_IDX    = out_sum.idx;
  assign FIRST_COL  = out_sum.first;
  assign LAST_COL   = out_sum.last;
  assign EDGE_CNT   = out_sum.cnt;
  assign FRAME_DONE = frame_done_q;
  assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_edge_scan_controller.sv
// Randomized self-checking bench for edge_scan_controller against a
// column-by-column reference model of the row summary.
module tb_edge_scan_controller;

  localparam int WIDTH  = 176;
  localparam int HEIGHT = 144;
  localparam int TAPS   = 11;
  localparam int CENTER = 5;
  localparam int THRESH = 3;
`ifdef EDGE_DEBOUNCE_EN
  localparam bit DEBOUNCE = 1'b1;
`else
  localparam bit DEBOUNCE = 1'b0;
`endif

  typedef struct {
    int idx;
    int first;
    int last;
    int cnt;
  } sum_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       VSYNC;
  logic       HREF;
  logic       PIX_VALID;
  logic [2:0] PIX;
  logic       ROW_VALID;
  logic       ROW_READY;
  logic [7:0] ROW_IDX;
  logic [7:0] FIRST_COL;
  logic [7:0] LAST_COL;
  logic [7:0] EDGE_CNT;
  logic       FRAME_DONE;
  logic       OVERRUN;

  int   n_total = 0;
  int   n_bad   = 0;
  int   fd_count = 0;
  sum_t exp_q[$];
  int   line_buf[300];
  int   model_row;
  bit   model_active;

  edge_scan_controller dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .VSYNC      (VSYNC),
    .HREF       (HREF),
    .PIX_VALID  (PIX_VALID),
    .PIX        (PIX),
    .ROW_VALID  (ROW_VALID),
    .ROW_READY  (ROW_READY),
    .ROW_IDX    (ROW_IDX),
    .FIRST_COL  (FIRST_COL),
    .LAST_COL   (LAST_COL),
    .EDGE_CNT   (EDGE_CNT),
    .FRAME_DONE (FRAME_DONE),
    .OVERRUN    (OVERRUN)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference summary straight from the edge definition, one column at a time
  function automatic sum_t model_line(input int n, input int idx);
    sum_t r;
    int   m;
    int   s;
    bit   e;
    bit   prev;
    r.idx = idx; r.first = 255; r.last = 255; r.cnt = 0;
    prev = 1'b0;
    m = (n < WIDTH) ? n : WIDTH;
    for (int c = CENTER; c + (TAPS - 1 - CENTER) < m; c++) begin
      s = 0;
      for (int k = c - CENTER; k <= c + TAPS - 1 - CENTER; k++) s += line_buf[k];
      e = (s > THRESH) && (line_buf[c] == 0);
      if (e && r.first == 255) r.first = c;
      if (e && (!DEBOUNCE || !prev)) begin
        r.last = c;
        if (r.cnt < 255) r.cnt++;
      end
      prev = e;
    end
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic vsync_pulse();
    VSYNC = 1'b1;
    @(posedge CLK); #1;
    VSYNC = 1'b0;
    model_row = 0;
    model_active = 1'b1;
  endtask

  task automatic rand_line(input int n);
    for (int c = 0; c < n; c++)
      line_buf[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
  endtask

  // Drives one HREF line with random PIX_VALID gaps; abort_col >= 0 raises VSYNC there
  task automatic send_line(input int n, input int abort_col, input bit publish);
    int c;
    bit aborted;
    c = 0; aborted = 1'b0;
    HREF = 1'b1; PIX_VALID = 1'b0; PIX = 3'($urandom);
    @(posedge CLK); #1;
    while (c < n && !aborted) begin
      if (c == abort_col) begin
        VSYNC = 1'b1; PIX_VALID = 1'b1; PIX = 3'(line_buf[c]);
        @(posedge CLK); #1;
        VSYNC = 1'b0;
        aborted = 1'b1;
      end else begin
        if ($urandom_range(0, 7) == 0) begin
          PIX_VALID = 1'b0; PIX = 3'($urandom);
        end else begin
          PIX_VALID = 1'b1; PIX = 3'(line_buf[c]); c++;
        end
        @(posedge CLK); #1;
      end
    end
    HREF = 1'b0; PIX_VALID = 1'b0;
    if (aborted) begin
      model_row = 0;
      model_active = 1'b1;
    end else if (model_active) begin
      if (publish) exp_q.push_back(model_line(n, model_row));
      model_row++;
      if (model_row == HEIGHT) model_active = 1'b0;
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_row_valid", int'(ROW_VALID), 0);
    chk("rst_row_idx", int'(ROW_IDX), 0);
    chk("rst_first_col", int'(FIRST_COL), 255);
    chk("rst_last_col", int'(LAST_COL), 255);
    chk("rst_edge_cnt", int'(EDGE_CNT), 0);
    chk("rst_frame_done", int'(FRAME_DONE), 0);
    chk("rst_overrun", int'(OVERRUN), 0);
  endtask

  // Consumer-side monitor: every accepted summary must match the model queue
  initial begin : monitor
    bit   fd_pend;
    sum_t e;
    fd_pend = 1'b0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        fd_pend = 1'b0;
      end else begin
        if (FRAME_DONE || fd_pend) chk("frame_done", int'(FRAME_DONE), int'(fd_pend));
        if (FRAME_DONE) fd_count++;
        fd_pend = 1'b0;
        if (ROW_VALID && ROW_READY) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_row", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("row_idx", int'(ROW_IDX), e.idx);
            chk("first_col", int'(FIRST_COL), e.first);
            chk("last_col", int'(LAST_COL), e.last);
            chk("edge_cnt", int'(EDGE_CNT), e.cnt);
            fd_pend = (e.idx == HEIGHT - 1);
          end
        end
      end
    end
  end

  initial begin : main
    int   lat;
    int   n;
    sum_t e;
    RESET = 1'b1; VSYNC = 1'b0; HREF = 1'b0; PIX_VALID = 1'b0; PIX = '0;
    ROW_READY = 1'b0; model_row = 0; model_active = 1'b0;
    repeat (3) @(posedge CLK); #1;
    check_reset_vals();
    RESET = 1'b0;
    idle(2);
    chk("post_rst_row_valid", int'(ROW_VALID), 0);

    // Directed line: ones at columns 20..23, latency measured from HREF fall
    ROW_READY = 1'b1;
    vsync_pulse();
    for (int c = 0; c < WIDTH; c++) line_buf[c] = (c >= 20 && c <= 23) ? 1 : 0;
    send_line(WIDTH, -1, 1'b1);
    lat = 0;
    while (!ROW_VALID && lat < 10) begin
      @(negedge CLK);
      lat++;
    end
    chk("latency", lat, 3);
    chk("t1_first", int'(FIRST_COL), 18);
    chk("t1_last", int'(LAST_COL), DEBOUNCE ? 24 : 25);
    chk("t1_cnt", int'(EDGE_CNT), DEBOUNCE ? 2 : 4);
    idle(4);

    // Saturated line: no dark centre anywhere
    for (int c = 0; c < WIDTH; c++) line_buf[c] = 7;
    send_line(WIDTH, -1, 1'b1);
    idle(6);

    // Over-long line: activity only beyond the last active column
    for (int c = 0; c < 200; c++) line_buf[c] = (c >= 180 && c <= 183) ? 1 : 0;
    send_line(200, -1, 1'b1);
    idle(6);

    // Consumer stalled across two lines: first summary held, second dropped
    ROW_READY = 1'b0;
    rand_line(WIDTH); send_line(WIDTH, -1, 1'b1); idle(6);
    rand_line(WIDTH); send_line(WIDTH, -1, 1'b0); idle(6);
    @(negedge CLK);
    chk("overrun_set", int'(OVERRUN), 1);
    chk("held_valid", int'(ROW_VALID), 1);
    e = exp_q[0];
    chk("held_idx", int'(ROW_IDX), e.idx);
    chk("held_first", int'(FIRST_COL), e.first);
    chk("held_last", int'(LAST_COL), e.last);
    chk("held_cnt", int'(EDGE_CNT), e.cnt);
    @(posedge CLK); #1;
    vsync_pulse();
    @(negedge CLK);
    chk("overrun_clr", int'(OVERRUN), 0);
    chk("vsync_keeps_valid", int'(ROW_VALID), 1);
    @(posedge CLK); #1;
    ROW_READY = 1'b1;
    idle(3);
    chk("drained_q", exp_q.size(), 0);
    chk("drained_valid", int'(ROW_VALID), 0);

    // Mid-line VSYNC: aborted line publishes nothing, next line is row 0
    rand_line(WIDTH); send_line(WIDTH, -1, 1'b1); idle(6);
    rand_line(WIDTH); send_line(WIDTH, 60, 1'b1); idle(6);
    chk("abort_no_row", int'(ROW_VALID), 0);
    rand_line(WIDTH); send_line(WIDTH, -1, 1'b1); idle(6);

    // Full frame of random lines, some short, some over-long
    vsync_pulse();
    for (int r = 0; r < HEIGHT; r++) begin
      case ($urandom_range(0, 3))
        0: n = int'($urandom_range(100, WIDTH - 1));
        1: n = int'($urandom_range(WIDTH + 1, WIDTH + 40));
        default: n = WIDTH;
      endcase
      rand_line(n);
      send_line(n, -1, 1'b1);
      idle(3);
    end
    idle(6);
    chk("frame_done_count", fd_count, 1);
    chk("frame_overrun", int'(OVERRUN), 0);
    chk("frame_q_empty", exp_q.size(), 0);

    // After the last row the controller sits in IDLE and ignores lines
    rand_line(WIDTH); send_line(WIDTH, -1, 1'b1); idle(6);
    chk("idle_no_row", int'(ROW_VALID), 0);

    // Reset in the middle of a line
    vsync_pulse();
    HREF = 1'b1; PIX_VALID = 1'b1; PIX = 3'd1;
    repeat (40) @(posedge CLK);
    #1;
    RESET = 1'b1;
    #1;
    check_reset_vals();
    HREF = 1'b0; PIX_VALID = 1'b0;
    idle(2);
    RESET = 1'b0; model_active = 1'b0; model_row = 0;
    idle(10);
    chk("rst_mid_no_row", int'(ROW_VALID), 0);

    chk("final_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
